// File: rtl/seg7_pattern_decoder.sv
// Decodes an active-low 7-segment pattern bus back to a BCD digit, with glitch filtering
// and a valid/ready output. Define SEG7DEC_ERRCNT_EN to add the saturating err_cnt port.
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACCEPT_ALT7   = 1'b1
`ifdef SEG7DEC_ERRCNT_EN
  ,
  parameter int ERRCNT_W      = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [3:0] dout_bcd,
  output logic       dout_err
`ifdef SEG7DEC_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT} state_t;

  state_t        state, state_n;
  logic [6:0]    seg_q;
  logic [6:0]    cand, cand_n;
  logic [6:0]    last, last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          valid_n;
  logic [3:0]    bcd_n;
  logic          err_n;

  // Returns {err, bcd}; anything outside the digit table is an error.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: decode = {1'b0, 4'd0};
      7'b1111001: decode = {1'b0, 4'd1};
      7'b0100100: decode = {1'b0, 4'd2};
      7'b0110000: decode = {1'b0, 4'd3};
      7'b0011001: decode = {1'b0, 4'd4};
      7'b0010010: decode = {1'b0, 4'd5};
      7'b0000010: decode = {1'b0, 4'd6};
      7'b1111000: decode = {1'b0, 4'd7};
      7'b0000000: decode = {1'b0, 4'd8};
      7'b0010000: decode = {1'b0, 4'd9};
      7'b1011000: decode = ACCEPT_ALT7 ? {1'b0, 4'd7} : {1'b1, 4'hF};
      default:    decode = {1'b1, 4'hF};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      seg_q      <= BLANK;
      cand       <= BLANK;
      last       <= BLANK;
      cnt        <= '0;
      dout_valid <= 1'b0;
      dout_bcd   <= 4'd0;
      dout_err   <= 1'b0;
    end else begin
      state      <= state_n;
      seg_q      <= seg_in;
      cand       <= cand_n;
      last       <= last_n;
      cnt        <= cnt_n;
      dout_valid <= valid_n;
      dout_bcd   <= bcd_n;
      dout_err   <= err_n;
    end
  end

  // A pattern must repeat STABLE_CYCLES times in a row; any deviation restarts the run.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    last_n  = last;
    cnt_n   = cnt;
    valid_n = dout_valid;
    bcd_n   = dout_bcd;
    err_n   = dout_err;
    case (state)
      IDLE: begin
        if (seg_q != last) begin
          cand_n  = seg_q;
          cnt_n   = CW'(1);
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (seg_q != cand) begin
          cand_n = seg_q;
          cnt_n  = CW'(1);
        end else if (cnt == CNT_LAST) begin
          if (cand == BLANK) begin
            last_n  = cand;
            state_n = IDLE;
          end else begin
            {err_n, bcd_n} = decode(cand);
            valid_n        = 1'b1;
            state_n        = EMIT;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      EMIT: begin
        if (dout_valid && dout_ready) begin
          valid_n = 1'b0;
          last_n  = cand;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef SEG7DEC_ERRCNT_EN
  logic err_inc;
  assign err_inc = (state == SETTLE) && (state_n == EMIT) && err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_inc && !(&err_cnt)) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Self-checking bench for seg7_pattern_decoder: directed scenarios plus a randomized
// run against a window-based reference model of the glitch filter.
module tb_seg7_pattern_decoder;

  localparam int SC = 4;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] ALT7  = 7'b1011000;
  localparam logic [6:0] BADP  = 7'b0001111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic       dout_ready = 1'b1;
  logic       dout_valid;
  logic [3:0] dout_bcd;
  logic       dout_err;
`ifdef SEG7DEC_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int total = 0;
  int bad = 0;

  logic [6:0] pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  logic [4:0] acc [$];

  seg7_pattern_decoder #(
    .STABLE_CYCLES(SC),
    .ACCEPT_ALT7(1'b1)
`ifdef SEG7DEC_ERRCNT_EN
    ,
    .ERRCNT_W(8)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .seg_in(seg_in),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_bcd(dout_bcd),
    .dout_err(dout_err)
`ifdef SEG7DEC_ERRCNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Records every accepted transfer as {err, bcd}.
  always @(posedge clk) begin
    if (!rst && dout_valid && dout_ready) acc.push_back({dout_err, dout_bcd});
  end

  // Reference model: a window of samples taken since the filter armed; a pattern is
  // accepted once the newest SC samples agree.
  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (p == pats[i]) return {1'b0, 4'(i)};
    if (p == ALT7) return {1'b0, 4'd7};
    return {1'b1, 4'hF};
  endfunction

  logic [6:0] m_q, m_last, m_emit;
  logic [6:0] win [$];
  logic       armed, m_valid, m_err, same;
  logic [3:0] m_bcd;
  logic [7:0] m_errcnt;

  always @(posedge clk) begin
    if (rst) begin
      m_q = BLANK; m_last = BLANK; m_emit = BLANK; win.delete(); armed = 1'b0;
      m_valid = 1'b0; m_bcd = 4'd0; m_err = 1'b0; m_errcnt = 8'd0;
    end else begin
      if (m_valid) begin
        if (dout_ready) begin
          m_valid = 1'b0;
          m_last  = m_emit;
        end
      end else if (!armed) begin
        if (m_q != m_last) begin
          win.delete();
          win.push_back(m_q);
          armed = 1'b1;
        end
      end else begin
        win.push_back(m_q);
        if (win.size() > SC) void'(win.pop_front());
        same = 1'b1;
        for (int i = 1; i < win.size(); i++) if (win[i] != win[0]) same = 1'b0;
        if (win.size() == SC && same) begin
          armed = 1'b0;
          if (win[0] == BLANK) begin
            m_last = win[0];
          end else begin
            {m_err, m_bcd} = ref_decode(win[0]);
            m_valid = 1'b1;
            m_emit  = win[0];
            if (m_err && m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
          end
        end
      end
      m_q = seg_in;
    end
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; seg_in = BLANK; dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", dout_valid); end
    total++; if (dout_bcd !== 4'd0) begin bad++; $display("[TB] FAIL reset_bcd got=%h exp=0", dout_bcd); end
    total++; if (dout_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", dout_err); end
`ifdef SEG7DEC_ERRCNT_EN
    total++; if (err_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_errcnt got=%0d exp=0", err_cnt); end
`endif
    rst = 1'b0;
    acc.delete();
    repeat (8) @(negedge clk);
    total++; if (acc.size() != 0) begin bad++; $display("[TB] FAIL blank_no_emit got=%0d exp=0", acc.size()); end
  endtask

  task automatic test_single();
    acc.delete();
    seg_in = pats[1];
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      total++;
      if (dout_valid !== (k == 4)) begin
        bad++; $display("[TB] FAIL single_valid k=%0d got=%b exp=%b", k, dout_valid, (k == 4));
      end
      if (k == 4) begin
        total++; if (dout_bcd !== 4'd1) begin bad++; $display("[TB] FAIL single_bcd got=%h exp=1", dout_bcd); end
        total++; if (dout_err !== 1'b0) begin bad++; $display("[TB] FAIL single_err got=%b exp=0", dout_err); end
      end
    end
    total++; if (acc.size() != 1) begin bad++; $display("[TB] FAIL single_count got=%0d exp=1", acc.size()); end
  endtask

  task automatic test_sweep();
    logic [4:0] got, exp;
    acc.delete();
    for (int d = 0; d < 10; d++) begin
      seg_in = pats[d];
      repeat (10) @(negedge clk);
    end
    seg_in = ALT7;
    repeat (10) @(negedge clk);
    total++; if (acc.size() != 11) begin bad++; $display("[TB] FAIL sweep_count got=%0d exp=11", acc.size()); end
    for (int i = 0; i < 11; i++) begin
      got = (i < acc.size()) ? acc[i] : 5'h1F;
      exp = (i < 10) ? 5'(i) : 5'd7;
      total++;
      if (got !== exp) begin bad++; $display("[TB] FAIL sweep_digit i=%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_glitch();
    acc.delete();
    for (int c = 0; c < 15; c++) begin
      seg_in = (c % 3 == 2) ? 7'b0000000 : pats[3];
      @(negedge clk);
    end
    total++; if (acc.size() != 0) begin bad++; $display("[TB] FAIL glitch_quiet got=%0d exp=0", acc.size()); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL glitch_valid got=%b exp=0", dout_valid); end
    seg_in = pats[3];
    repeat (8) @(negedge clk);
    total++; if (acc.size() != 1) begin bad++; $display("[TB] FAIL glitch_count got=%0d exp=1", acc.size()); end
    else begin
      total++; if (acc[0] !== 5'h03) begin bad++; $display("[TB] FAIL glitch_digit got=%h exp=03", acc[0]); end
    end
  endtask

  task automatic test_back_to_back();
    acc.delete();
    dout_ready = 1'b0;
    seg_in = pats[2];
    repeat (6) @(negedge clk);
    total++; if (dout_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid got=%b exp=1", dout_valid); end
    total++; if (dout_bcd !== 4'd2) begin bad++; $display("[TB] FAIL bp_bcd got=%h exp=2", dout_bcd); end
    seg_in = pats[5];
    repeat (6) @(negedge clk);
    total++; if (dout_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_valid got=%b exp=1", dout_valid); end
    total++; if (dout_bcd !== 4'd2) begin bad++; $display("[TB] FAIL bp_hold_bcd got=%h exp=2", dout_bcd); end
    total++; if (dout_err !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold_err got=%b exp=0", dout_err); end
    dout_ready = 1'b1;
    repeat (8) @(negedge clk);
    total++; if (acc.size() != 2) begin bad++; $display("[TB] FAIL bp_count got=%0d exp=2", acc.size()); end
    else begin
      total++; if (acc[0] !== 5'h02) begin bad++; $display("[TB] FAIL bp_first got=%h exp=02", acc[0]); end
      total++; if (acc[1] !== 5'h05) begin bad++; $display("[TB] FAIL bp_second got=%h exp=05", acc[1]); end
    end
  endtask

  task automatic test_illegal();
    acc.delete();
    seg_in = BADP;
    repeat (8) @(negedge clk);
    total++; if (acc.size() != 1 || acc[0] !== 5'h1F) begin
      bad++; $display("[TB] FAIL illegal_first got=%0d/%h exp=1/1f", acc.size(), (acc.size() > 0) ? acc[0] : 5'h0);
    end
`ifdef SEG7DEC_ERRCNT_EN
    total++; if (err_cnt !== 8'd1) begin bad++; $display("[TB] FAIL errcnt_one got=%0d exp=1", err_cnt); end
`endif
    seg_in = BLANK;
    repeat (8) @(negedge clk);
    seg_in = BADP;
    repeat (8) @(negedge clk);
    total++; if (acc.size() != 2 || acc[acc.size()-1] !== 5'h1F) begin
      bad++; $display("[TB] FAIL illegal_repeat got=%0d exp=2", acc.size());
    end
`ifdef SEG7DEC_ERRCNT_EN
    total++; if (err_cnt !== 8'd2) begin bad++; $display("[TB] FAIL errcnt_two got=%0d exp=2", err_cnt); end
`endif
  endtask

  task automatic test_rearm_reset();
    acc.delete();
    seg_in = pats[4]; repeat (8) @(negedge clk);
    seg_in = BLANK;   repeat (8) @(negedge clk);
    seg_in = pats[4]; repeat (8) @(negedge clk);
    total++; if (acc.size() != 2) begin bad++; $display("[TB] FAIL rearm_count got=%0d exp=2", acc.size()); end
    else begin
      total++; if (acc[0] !== 5'h04 || acc[1] !== 5'h04) begin
        bad++; $display("[TB] FAIL rearm_digits got=%h,%h exp=04,04", acc[0], acc[1]);
      end
    end
    acc.delete();
    seg_in = pats[9];
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_settle_valid got=%b exp=0", dout_valid); end
`ifdef SEG7DEC_ERRCNT_EN
    total++; if (err_cnt !== 8'd0) begin bad++; $display("[TB] FAIL rst_errcnt got=%0d exp=0", err_cnt); end
`endif
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++;
      if (dout_valid !== (k == 5)) begin
        bad++; $display("[TB] FAIL post_rst_valid k=%0d got=%b exp=%b", k, dout_valid, (k == 5));
      end
    end
    total++; if (acc.size() != 1 || acc[0] !== 5'h09) begin
      bad++; $display("[TB] FAIL post_rst_digit got=%0d/%h exp=1/09", acc.size(), (acc.size() > 0) ? acc[0] : 5'h0);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    int sel;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      total++;
      if (dout_valid !== m_valid) begin
        bad++; $display("[TB] FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, dout_valid, m_valid);
      end
      if (m_valid) begin
        total++;
        if (dout_bcd !== m_bcd || dout_err !== m_err) begin
          bad++; $display("[TB] FAIL rand_data cyc=%0d got=%b/%h exp=%b/%h", cyc, dout_err, dout_bcd, m_err, m_bcd);
        end
      end
`ifdef SEG7DEC_ERRCNT_EN
      total++;
      if (err_cnt !== m_errcnt) begin
        bad++; $display("[TB] FAIL rand_errcnt cyc=%0d got=%0d exp=%0d", cyc, err_cnt, m_errcnt);
      end
`endif
      if (hold == 0) begin
        sel = $urandom_range(0, 15);
        if (sel < 10)      seg_in = pats[sel];
        else if (sel == 10) seg_in = ALT7;
        else if (sel < 13) seg_in = BLANK;
        else               seg_in = 7'($urandom);
        hold = $urandom_range(1, 7);
      end
      hold--;
      dout_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_glitch();
    test_back_to_back();
    test_illegal();
    test_rearm_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
